dram_addr_gen_pipe: RTL and testbench

DRAM_ADDR_GEN_PIPE -- requirements
Module: dram_addr_gen_pipe

---
 rtl/dram_addr_gen_pipe.sv | 182 ++++++++++++++++++
 tb/tb_dram_addr_gen_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_addr_gen_pipe.sv
// DRAM address decoder: bank/rank/row/column split, parity, range check and open-row tracking.
// Two-cycle latency at one request per cycle; the output register holds while out_ready is low.
module dram_addr_gen_pipe #(
   parameter int PA_W     = 40,
   parameter int RAS_W    = 15,
   parameter int CAS_W    = 12,
   parameter int ERRCNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [PA_W-5:0]     addr_in,
   input  logic                cfg_wr,
   input  logic                cfg_two_chan,
   input  logic                cfg_eight_bank,
   input  logic                cfg_rank1,
   input  logic                cfg_cas12,
   input  logic                cfg_ras15,
   input  logic                prech_all,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [RAS_W-1:0]    out_ras,
   output logic [CAS_W-1:0]    out_cas,
   output logic [2:0]          out_bank,
   output logic                out_rank,
   output logic                out_err,
   output logic                out_parity,
   output logic                out_page_hit,
   output logic [ERRCNT_W-1:0] err_cnt
);

   logic r_cfg_two_chan, r_cfg_eight_bank, r_cfg_rank1, r_cfg_cas12, r_cfg_ras15;
   logic r_lat_two_chan, r_lat_eight_bank, r_lat_rank1, r_lat_cas12, r_lat_ras15;
   logic r_cfg_pend;

   logic             r_s1_vld, r_s1_rank, r_s1_err, r_s1_parity;
   logic [RAS_W-1:0] r_s1_ras;
   logic [CAS_W-1:0] r_s1_cas;
   logic [2:0]       r_s1_bank;

   logic             r_s2_vld, r_out_rank, r_out_err, r_out_parity, r_out_page_hit;
   logic [RAS_W-1:0] r_out_ras;
   logic [CAS_W-1:0] r_out_cas;
   logic [2:0]       r_out_bank;
   logic [ERRCNT_W-1:0] r_err_cnt;

   logic [15:0]      r_tbl_vld;
   logic [RAS_W-1:0] r_tbl_row [16];

   // Field offsets move with the active configuration.
   logic [PA_W-1:0] w_addr;
   logic [5:0]      w_b, w_c, w_r, w_top;
   logic [3:0]      w_bank_raw;
   logic [2:0]      w_bank;
   logic            w_rank, w_err, w_parity;
   logic [9:0]      w_cas_fld;
   logic [14:0]     w_ras_fld;

   assign w_addr = {addr_in, 4'b0000};
   assign w_b    = r_cfg_two_chan ? 6'd7 : 6'd8;
   assign w_c    = w_b + (r_cfg_eight_bank ? 6'd3 : 6'd2) + (r_cfg_rank1 ? 6'd1 : 6'd0);
   assign w_r    = w_c + (r_cfg_cas12 ? 6'd10 : 6'd9);
   assign w_top  = w_r + (r_cfg_ras15 ? 6'd15 : 6'd14);

   assign w_bank_raw = 4'(w_addr >> w_b);
   assign w_bank     = (w_bank_raw[2:0] ^ w_addr[20:18] ^ w_addr[30:28])
                       & {r_cfg_eight_bank, 2'b11};
   assign w_rank     = r_cfg_rank1 & (r_cfg_eight_bank ? w_bank_raw[3] : w_bank_raw[2]);
   assign w_cas_fld  = 10'(w_addr >> w_c) & {r_cfg_cas12, 9'h1FF};
   assign w_ras_fld  = 15'(w_addr >> w_r) & {r_cfg_ras15, 14'h3FFF};
   assign w_err      = |(w_addr >> w_top);
   assign w_parity   = ^(w_addr >> w_b);

   logic       w_s2_adv, w_s1_adv, w_acc, w_s2_load, w_cfg_apply, w_hit;
   logic [3:0] w_idx;

   assign w_s2_adv    = !r_s2_vld || out_ready;
   assign w_s1_adv    = w_s2_adv || !r_s1_vld;
   assign in_ready    = w_s1_adv && !r_cfg_pend;
   assign w_acc       = in_valid && in_ready;
   assign w_s2_load   = w_s2_adv && r_s1_vld;
   assign w_cfg_apply = r_cfg_pend && !r_s1_vld && !r_s2_vld;
   assign w_idx       = {r_s1_rank, r_s1_bank};
   // A coincident precharge makes the loading request miss.
   assign w_hit       = !r_s1_err && !prech_all && r_tbl_vld[w_idx]
                        && (r_tbl_row[w_idx] == r_s1_ras);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cfg_two_chan   <= 1'b0;
         r_cfg_eight_bank <= 1'b1;
         r_cfg_rank1      <= 1'b1;
         r_cfg_cas12      <= 1'b0;
         r_cfg_ras15      <= 1'b0;
         r_lat_two_chan   <= 1'b0;
         r_lat_eight_bank <= 1'b1;
         r_lat_rank1      <= 1'b1;
         r_lat_cas12      <= 1'b0;
         r_lat_ras15      <= 1'b0;
         r_cfg_pend       <= 1'b0;
         r_s1_vld         <= 1'b0;
         r_s1_ras         <= '0;
         r_s1_cas         <= '0;
         r_s1_bank        <= '0;
         r_s1_rank        <= 1'b0;
         r_s1_err         <= 1'b0;
         r_s1_parity      <= 1'b0;
         r_s2_vld         <= 1'b0;
         r_out_ras        <= '0;
         r_out_cas        <= '0;
         r_out_bank       <= '0;
         r_out_rank       <= 1'b0;
         r_out_err        <= 1'b0;
         r_out_parity     <= 1'b0;
         r_out_page_hit   <= 1'b0;
         r_err_cnt        <= '0;
         r_tbl_vld        <= '0;
         for (int i = 0; i < 16; i++) r_tbl_row[i] <= '0;
      end else begin
         if (w_s1_adv) begin
            r_s1_vld <= w_acc;
            if (w_acc) begin
               r_s1_ras    <= RAS_W'(w_ras_fld);
               r_s1_cas    <= CAS_W'({w_cas_fld, w_addr[5:4]});
               r_s1_bank   <= w_bank;
               r_s1_rank   <= w_rank;
               r_s1_err    <= w_err;
               r_s1_parity <= w_parity;
            end
         end
         if (w_s2_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
               r_out_ras      <= r_s1_ras;
               r_out_cas      <= r_s1_cas;
               r_out_bank     <= r_s1_bank;
               r_out_rank     <= r_s1_rank;
               r_out_err      <= r_s1_err;
               r_out_parity   <= r_s1_parity;
               r_out_page_hit <= w_hit;
            end
         end
         // Clear first so a same-edge write from S2 wins.
         if (prech_all || w_cfg_apply) r_tbl_vld <= '0;
         if (w_s2_load && !r_s1_err) begin
            r_tbl_vld[w_idx] <= 1'b1;
            r_tbl_row[w_idx] <= r_s1_ras;
         end
         if (cfg_wr) begin
            r_cfg_pend       <= 1'b1;
            r_lat_two_chan   <= cfg_two_chan;
            r_lat_eight_bank <= cfg_eight_bank;
            r_lat_rank1      <= cfg_rank1;
            r_lat_cas12      <= cfg_cas12;
            r_lat_ras15      <= cfg_ras15;
         end else if (w_cfg_apply) begin
            r_cfg_pend <= 1'b0;
         end
         if (w_cfg_apply) begin
            r_cfg_two_chan   <= r_lat_two_chan;
            r_cfg_eight_bank <= r_lat_eight_bank;
            r_cfg_rank1      <= r_lat_rank1;
            r_cfg_cas12      <= r_lat_cas12;
            r_cfg_ras15      <= r_lat_ras15;
         end
         if (r_s2_vld && out_ready && r_out_err && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign out_valid    = r_s2_vld;
   assign out_ras      = r_out_ras;
   assign out_cas      = r_out_cas;
   assign out_bank     = r_out_bank;
   assign out_rank     = r_out_rank;
   assign out_err      = r_out_err;
   assign out_parity   = r_out_parity;
   assign out_page_hit = r_out_page_hit;
   assign err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_dram_addr_gen_pipe.sv
// Scoreboard bench for dram_addr_gen_pipe: reference decode and open-row model run at accept time.
// Inputs change just after posedge; acceptance and outputs are sampled at negedge.
module tb_dram_addr_gen_pipe;

   localparam int PA_W = 40;

   typedef struct packed {
      logic [14:0] ras;
      logic [11:0] cas;
      logic [2:0]  bank;
      logic        rank;
      logic        err;
      logic        par;
      logic        hit;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [PA_W-5:0] addr_in;
   logic        cfg_wr, cfg_two_chan, cfg_eight_bank, cfg_rank1, cfg_cas12, cfg_ras15;
   logic        prech_all;
   logic        out_valid, out_ready;
   logic [14:0] out_ras;
   logic [11:0] out_cas;
   logic [2:0]  out_bank;
   logic        out_rank, out_err, out_parity, out_page_hit;
   logic [7:0]  err_cnt;

   dram_addr_gen_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .addr_in(addr_in),
      .cfg_wr(cfg_wr), .cfg_two_chan(cfg_two_chan), .cfg_eight_bank(cfg_eight_bank),
      .cfg_rank1(cfg_rank1), .cfg_cas12(cfg_cas12), .cfg_ras15(cfg_ras15),
      .prech_all(prech_all), .out_valid(out_valid), .out_ready(out_ready),
      .out_ras(out_ras), .out_cas(out_cas), .out_bank(out_bank), .out_rank(out_rank),
      .out_err(out_err), .out_parity(out_parity), .out_page_hit(out_page_hit),
      .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model state
   logic        m_two, m_eight, m_rank1, m_cas12, m_ras15;
   logic [15:0] m_vld;
   logic [14:0] m_row [16];
   int          m_errcnt;
   logic [39:0] stim_q [$];
   exp_t        exp_q [$];
   exp_t        last_obs;

   function automatic exp_t decode(input logic [39:0] a);
      exp_t e;
      int b, nb, cw, rw, c, r;
      b  = m_two ? 7 : 8;
      nb = m_eight ? 3 : 2;
      cw = m_cas12 ? 12 : 11;
      rw = m_ras15 ? 15 : 14;
      e = '0;
      for (int i = 0; i < nb; i++) e.bank[i] = a[b+i] ^ a[18+i] ^ a[28+i];
      e.rank = m_rank1 ? a[b+nb] : 1'b0;
      c = b + nb + (m_rank1 ? 1 : 0);
      e.cas[1:0] = a[5:4];
      for (int i = 0; i < cw-2; i++) e.cas[2+i] = a[c+i];
      r = c + cw - 2;
      for (int i = 0; i < rw; i++) e.ras[i] = a[r+i];
      for (int i = r + rw; i < PA_W; i++) e.err = e.err | a[i];
      for (int i = b; i < PA_W; i++) e.par = e.par ^ a[i];
      return e;
   endfunction

   task automatic push_expect(input logic [39:0] a);
      exp_t e;
      logic [3:0] idx;
      e = decode(a);
      idx = {e.rank, e.bank};
      e.hit = !e.err && m_vld[idx] && (m_row[idx] == e.ras);
      if (!e.err) begin
         m_vld[idx] = 1'b1;
         m_row[idx] = e.ras;
      end
      exp_q.push_back(e);
   endtask

   task automatic model_reset();
      m_two = 1'b0; m_eight = 1'b1; m_rank1 = 1'b1; m_cas12 = 1'b0; m_ras15 = 1'b0;
      m_vld = '0;
      m_errcnt = 0;
   endtask

   // Driver: presents the head of stim_q until it is taken.
   initial begin
      in_valid = 1'b0;
      addr_in  = '0;
      forever begin
         @(posedge clk); #1;
         if (!rst && stim_q.size() > 0) begin
            in_valid = 1'b1;
            addr_in  = stim_q[0][39:4];
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (in_valid && in_ready && !rst && stim_q.size() > 0) push_expect(stim_q.pop_front());
      end
   end

   // Monitor: held or consumed outputs must match the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("err_cnt", err_cnt, m_errcnt[7:0]);
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  check("spurious_out_valid", out_valid, 1'b0);
               end else begin
                  check("out_fields", {out_ras, out_cas, out_bank, out_rank, out_err,
                                       out_parity, out_page_hit}, exp_q[0]);
                  if (out_ready) begin
                     e = exp_q.pop_front();
                     last_obs = {out_ras, out_cas, out_bank, out_rank, out_err,
                                 out_parity, out_page_hit};
                     if (e.err && m_errcnt < 255) m_errcnt++;
                  end
               end
            end
         end
      end
   end

   task automatic wait_drain();
      logic done;
      done = 1'b0;
      for (int k = 0; k < 2000 && !done; k++) begin
         @(negedge clk);
         done = (stim_q.size() == 0) && (exp_q.size() == 0) && !out_valid;
      end
      check("drain_timeout", done, 1'b1);
   endtask

   task automatic wait_taken();
      logic done;
      done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         done = (stim_q.size() == 0);
      end
      check("accept_timeout", done, 1'b1);
   endtask

   task automatic cfg_pulse(input logic two, eight, rk, c12, r15);
      @(posedge clk); #2;
      cfg_wr = 1'b1;
      cfg_two_chan = two; cfg_eight_bank = eight; cfg_rank1 = rk;
      cfg_cas12 = c12; cfg_ras15 = r15;
      @(posedge clk); #2;
      cfg_wr = 1'b0;
   endtask

   function automatic logic [39:0] pick(input logic [39:0] pool [8]);
      if ($urandom_range(0, 4) != 0) return pool[$urandom_range(0, 7)];
      return {4'b0000, 4'($urandom), 32'($urandom)};
   endfunction

   localparam logic [39:0] ADDR_A   = 40'h00_0020_0F30;
   localparam logic [39:0] ADDR_ERR = 40'h08_0000_0000;

   initial begin
      logic [39:0] pool [8];
      rst = 1'b1; out_ready = 1'b1; prech_all = 1'b0; cfg_wr = 1'b0;
      cfg_two_chan = 1'b0; cfg_eight_bank = 1'b0; cfg_rank1 = 1'b0;
      cfg_cas12 = 1'b0; cfg_ras15 = 1'b0;
      model_reset();
      last_obs = '0;
      for (int i = 0; i < 8; i++) pool[i] = {5'b00000, 3'($urandom), 32'($urandom)};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_err_cnt", err_cnt, 8'd0);
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_reset", in_ready, 1'b1);

      // Known vector, then re-hit, then miss after precharge
      stim_q.push_back(ADDR_A); wait_drain();
      check("known_vector", last_obs, {15'd1, 12'h003, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0});
      stim_q.push_back(ADDR_A); wait_drain();
      check("repeat_page_hit", last_obs.hit, 1'b1);
      @(posedge clk); #2 prech_all = 1'b1; m_vld = '0;
      @(posedge clk); #2 prech_all = 1'b0;
      stim_q.push_back(ADDR_A); wait_drain();
      check("hit_after_prech", last_obs.hit, 1'b0);

      // Out-of-range requests and counter saturation
      stim_q.push_back(ADDR_ERR); wait_drain();
      check("err_flag", {last_obs.err, last_obs.hit}, 2'b10);
      check("err_cnt_one", err_cnt, 8'd1);
      for (int i = 0; i < 300; i++) stim_q.push_back(ADDR_ERR);
      wait_drain();
      check("err_cnt_saturated", err_cnt, 8'hFF);

      // Back-to-back burst against a three-cycle stall
      @(posedge clk); #2 out_ready = 1'b0;
      for (int i = 0; i < 4; i++) stim_q.push_back(pool[i]);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("stall_in_ready_low", in_ready, 1'b0);
      check("stall_queue_depth", exp_q.size(), 2);
      @(posedge clk); #2 out_ready = 1'b1;
      wait_drain();

      // Random traffic with random backpressure
      for (int i = 0; i < 150; i++) stim_q.push_back(pick(pool));
      for (int k = 0; k < 3000 && (stim_q.size() > 0 || exp_q.size() > 0); k++) begin
         @(posedge clk); #2 out_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #2 out_ready = 1'b1;
      wait_drain();

      // Config change with two requests in flight
      @(posedge clk); #2 out_ready = 1'b0;
      stim_q.push_back(ADDR_A); stim_q.push_back(ADDR_A);
      wait_taken();
      cfg_pulse(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      m_two = 1'b1; m_vld = '0;
      stim_q.push_back(ADDR_A);
      @(negedge clk);
      check("cfg_pend_in_ready_low", in_ready, 1'b0);
      repeat (2) @(posedge clk);
      #2 out_ready = 1'b1;
      wait_drain();
      check("cfg_applied_bank", last_obs.bank, 3'd6);
      check("cfg_table_cleared", last_obs.hit, 1'b0);

      // Second write while pending replaces the first
      @(posedge clk); #2 out_ready = 1'b0;
      stim_q.push_back(pool[5]);
      wait_taken();
      cfg_pulse(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      cfg_pulse(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      m_two = 1'b1; m_eight = 1'b0; m_rank1 = 1'b0; m_cas12 = 1'b1; m_ras15 = 1'b1;
      m_vld = '0;
      for (int i = 0; i < 80; i++) stim_q.push_back(pick(pool));
      @(posedge clk); #2 out_ready = 1'b1;
      wait_drain();

      // Reset in the middle of a stream
      for (int i = 0; i < 10; i++) stim_q.push_back(pool[i % 8]);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      stim_q.delete(); exp_q.delete();
      model_reset();
      #1;
      check("midreset_out_valid", out_valid, 1'b0);
      check("midreset_err_cnt", err_cnt, 8'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_midreset", in_ready, 1'b1);
      stim_q.push_back(pool[0]); wait_drain();
      check("post_reset_miss", last_obs.hit, 1'b0);
      stim_q.push_back(pool[0]); wait_drain();
      check("post_reset_rehit", last_obs.hit, pool[0][39:35] == 5'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
